// File: rtl/ether_tx.sv
// rtl/ether_tx.sv - RMII transmit framer: preamble, SFD, header, payload, pad, CRC-32 FCS, IFG
//
// Ports:
//   clk        50 MHz RMII reference clock
//   rst        asynchronous active-low reset
//   axiiv      payload byte valid from upstream FIFO
//   axiid      payload byte
//   axiilast   final payload byte of the frame
//   axiiready  byte accepted this cycle when axiiv is also high (combinational)
//   txen       RMII TX_EN
//   txd        RMII TXD, txd[0] carries the earlier bit
//   busy       high from frame start until the end of the interpacket gap
//   tx_done    one-cycle pulse after the last FCS dibit
//   tx_err     one-cycle pulse on underrun or oversize

module ether_tx #(
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC     = 48'h69_69_5A_06_54_91,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          IFG_CYCLES  = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    input  logic       axiilast,
    output logic       axiiready,
    output logic       txen,
    output logic [1:0] txd,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } state_t;

    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [15:0]  PRE_LAST = 16'd31;
    localparam logic [15:0]  HDR_LAST = 16'd55;
    localparam logic [15:0]  FCS_LAST = 16'd15;
    localparam logic [15:0]  IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [15:0]  MIN_LEN  = 16'(MIN_PAYLOAD);
    localparam logic [15:0]  MAX_LEN  = 16'(MAX_PAYLOAD);

    // state/cnt describe the dibit currently on the wire; the output
    // registers are loaded with the dibit belonging to the next state.
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] len, len_n;
    logic [7:0]  byte_q, byte_n;
    logic        last_q, last_n;
    logic [31:0] crc;
    logic [1:0]  dibit_n;
    logic [6:0]  hdr_pos;
    logic        done_n, err_n, in_frame_n;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Fetch slot: last dibit of the final header byte, and last dibit of
    // every payload byte that is not the frame's final one.
    assign axiiready = ((state == HEADER) && (cnt == HDR_LAST)) ||
                       ((state == PAYLOAD) && (cnt[1:0] == 2'd3) && !last_q);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        len_n   = len;
        byte_n  = byte_q;
        last_n  = last_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n  = '0;
                len_n  = '0;
                last_n = 1'b0;
                if (axiiv) state_n = PREAMBLE;
            end
            PREAMBLE: begin
                if (cnt == PRE_LAST) begin
                    state_n = HEADER;
                    cnt_n   = '0;
                end
            end
            HEADER: ;
            PAYLOAD: begin
                if ((cnt[1:0] == 2'd3) && last_q) begin
                    cnt_n = '0;
                    if (len < MIN_LEN) begin
                        state_n = PAD;
                        len_n   = len + 16'd1;
                    end else begin
                        state_n = FCS;
                    end
                end
            end
            PAD: begin
                if (cnt[1:0] == 2'd3) begin
                    if (len == MIN_LEN) begin
                        state_n = FCS;
                        cnt_n   = '0;
                    end else begin
                        len_n = len + 16'd1;
                    end
                end
            end
            FCS: begin
                if (cnt == FCS_LAST) begin
                    state_n = IFG;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end
            end
            IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (axiiready) begin
            cnt_n = '0;
            if (axiiv) begin
                state_n = PAYLOAD;
                byte_n  = axiid;
                len_n   = len + 16'd1;
                // Byte MAX_PAYLOAD closes the frame even without axiilast.
                last_n  = axiilast || ((len + 16'd1) == MAX_LEN);
                err_n   = !axiilast && ((len + 16'd1) == MAX_LEN);
            end else begin
                state_n = IFG;
                err_n   = 1'b1;
            end
        end
    end

    always_comb begin
        hdr_pos = 7'd104 - {cnt_n[5:2], 3'b000} + {4'b0000, cnt_n[1:0], 1'b0};
        dibit_n = 2'b00;
        case (state_n)
            PREAMBLE: dibit_n = (cnt_n == PRE_LAST) ? 2'b11 : 2'b01;
            HEADER:   dibit_n = HDR[hdr_pos +: 2];
            PAYLOAD:  dibit_n = byte_n[{cnt_n[1:0], 1'b0} +: 2];
            FCS:      dibit_n = ~crc[{cnt_n[3:0], 1'b0} +: 2];
            default:  dibit_n = 2'b00;
        endcase
        in_frame_n = (state_n == PREAMBLE) || (state_n == HEADER) || (state_n == PAYLOAD) ||
                     (state_n == PAD) || (state_n == FCS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            len     <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            crc     <= 32'hFFFFFFFF;
            txen    <= 1'b0;
            txd     <= 2'b00;
            busy    <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            len     <= len_n;
            byte_q  <= byte_n;
            last_q  <= last_n;
            txen    <= in_frame_n;
            txd     <= in_frame_n ? dibit_n : 2'b00;
            busy    <= (state_n != IDLE);
            tx_done <= done_n;
            tx_err  <= err_n;
            // The CRC tracks exactly the dibits loaded onto the wire; it
            // holds through FCS and reinitialises before the next frame.
            if ((state_n == HEADER) || (state_n == PAYLOAD) || (state_n == PAD))
                crc <= crc_step(crc, dibit_n);
            else if ((state_n == IDLE) || (state_n == PREAMBLE))
                crc <= 32'hFFFFFFFF;
        end
    end

endmodule

// File: tb/tb_ether_tx.sv
// tb/tb_ether_tx.sv - self-checking bench for ether_tx

module tb_ether_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       axiiv;
    logic [7:0] axiid;
    logic       axiilast;
    logic       axiiready;
    logic       txen;
    logic [1:0] txd;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    always #10 clk = ~clk;

    ether_tx dut (
        .clk       (clk),
        .rst       (rst),
        .axiiv     (axiiv),
        .axiid     (axiid),
        .axiilast  (axiilast),
        .axiiready (axiiready),
        .txen      (txen),
        .txd       (txd),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] pl [0:1599];
    logic [1:0] rx_q [$];
    logic [7:0] exp_b [$];

    int r_hs, r_rises, r_txstart, r_done_cnt, r_done_cyc, r_err_cnt, r_busy_fall;

    typedef struct {
        int n;
        bit set_last;
        int stall_at;
        int pat;
        int exp_hs;
        int exp_len;
        int exp_err;
        int exp_done;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    function automatic logic [31:0] crc_bytes(input logic [7:0] q [$], input int from);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = from; i < q.size(); i++)
            for (int j = 0; j < 8; j++)
                c = (c >> 1) ^ (((c[0] ^ q[i][j]) != 1'b0) ? 32'hEDB88320 : 32'h0);
        return c;
    endfunction

    // Expected wire bytes: preamble, SFD, header, k payload bytes, and for
    // a completed frame zero pad up to 46 bytes plus the inverted CRC.
    task automatic build_exp(input int k, input bit full);
        logic [7:0] hdr [14];
        logic [31:0] c;
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h69, 8'h69, 8'h5A, 8'h06, 8'h54, 8'h91, 8'h88, 8'hB5};
        exp_b.delete();
        for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
        exp_b.push_back(8'hD5);
        for (int i = 0; i < 14; i++) exp_b.push_back(hdr[i]);
        for (int i = 0; i < k; i++) exp_b.push_back(pl[i]);
        if (full) begin
            for (int i = k; i < 46; i++) exp_b.push_back(8'h00);
            c = ~crc_bytes(exp_b, 8);
            for (int i = 0; i < 4; i++) exp_b.push_back(c[8*i +: 8]);
        end
    endtask

    task automatic run_frame(input int n, input bit set_last, input int stall_at, input bit noise);
        int  idx  = 0;
        int  cyc  = 0;
        bit  seen = 0;
        bit  fin  = 0;
        bit  prev = 0;
        rx_q.delete();
        r_hs = 0; r_rises = 0; r_txstart = -1; r_done_cnt = 0; r_done_cyc = -1;
        r_err_cnt = 0; r_busy_fall = -1;
        while (!fin && cyc < 8000) begin
            @(negedge clk);
            if (txen) begin
                if (!prev) begin
                    r_rises++;
                    if (r_txstart < 0) r_txstart = cyc;
                end
                rx_q.push_back(txd);
            end
            prev = txen;
            if (tx_done) begin r_done_cnt++; r_done_cyc = cyc; end
            if (tx_err) r_err_cnt++;
            if (busy) seen = 1;
            else if (seen) begin r_busy_fall = cyc; fin = 1; end

            if (fin) begin
                axiiv = 1'b0; axiilast = 1'b0;
            end else if (cyc == 0) begin
                axiiv = 1'b1; axiid = pl[0]; axiilast = set_last && (n == 1);
            end else if (axiiready) begin
                if (idx == stall_at || idx >= n) begin
                    axiiv = 1'b0; axiilast = 1'b0;
                end else begin
                    axiiv = 1'b1; axiid = pl[idx]; axiilast = set_last && (idx == n - 1);
                    idx++; r_hs++;
                end
            end else if (noise) begin
                axiiv = 1'($urandom_range(0, 1)); axiid = 8'($urandom);
                axiilast = 1'($urandom_range(0, 1));
            end else if (idx < n && idx != stall_at) begin
                axiiv = 1'b1; axiid = pl[idx]; axiilast = set_last && (idx == n - 1);
            end else begin
                axiiv = 1'b0; axiilast = 1'b0;
            end
            cyc++;
        end
        check("frame_finished", fin, 1);
    endtask

    task automatic verify(input string tag, input int exp_hs, input int exp_len,
                          input int exp_err, input int exp_done);
        int          mism;
        logic [7:0]  b;
        logic [7:0]  rxb [$];
        check({tag, "_handshakes"}, r_hs, exp_hs);
        check({tag, "_txen_len"}, rx_q.size(), exp_len);
        check({tag, "_txen_rises"}, r_rises, 1);
        check({tag, "_tx_err"}, r_err_cnt, exp_err);
        check({tag, "_tx_done"}, r_done_cnt, exp_done);
        if (exp_done != 0) check({tag, "_done_cycle"}, r_done_cyc, r_txstart + exp_len);
        check({tag, "_busy_fall"}, r_busy_fall, r_txstart + exp_len + 48);
        build_exp(exp_hs, exp_done != 0);
        check({tag, "_model_len"}, exp_b.size() * 4, rx_q.size());
        mism = 0;
        for (int i = 0; i < rx_q.size() && i < exp_b.size() * 4; i++) begin
            b = exp_b[i / 4];
            if (rx_q[i] !== b[2 * (i % 4) +: 2]) mism++;
        end
        check({tag, "_dibit_mismatches"}, mism, 0);
        if (exp_done != 0) begin
            for (int i = 0; i + 3 < rx_q.size(); i += 4)
                rxb.push_back({rx_q[i + 3], rx_q[i + 2], rx_q[i + 1], rx_q[i]});
            check({tag, "_fcs_residue"}, crc_bytes(rxb, 8), 32'hDEBB20E3);
        end
    endtask

    initial begin
        int mism;
        int idx;
        int n, stall, k, elen;

        rst = 1'b0; axiiv = 1'b0; axiid = 8'h00; axiilast = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_txen", txen, 0);
        check("reset_txd", txd, 0);
        check("reset_axiiready", axiiready, 0);
        check("reset_busy", busy, 0);
        check("reset_tx_done", tx_done, 0);
        check("reset_tx_err", tx_err, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        vt[0] = '{1,    1'b1, -1, 1, 1,    288,  0, 1};
        vt[1] = '{60,   1'b1, -1, 0, 60,   344,  0, 1};
        vt[2] = '{45,   1'b1, -1, 2, 45,   288,  0, 1};
        vt[3] = '{46,   1'b1, -1, 2, 46,   288,  0, 1};
        vt[4] = '{47,   1'b1, -1, 2, 47,   292,  0, 1};
        vt[5] = '{20,   1'b1,  9, 2, 9,    124,  1, 0};
        vt[6] = '{20,   1'b1,  0, 2, 0,    88,   1, 0};
        vt[7] = '{1501, 1'b0, -1, 0, 1500, 6104, 1, 1};

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 1600; i++)
                pl[i] = (vt[v].pat == 0) ? 8'(i) : (vt[v].pat == 1) ? 8'hA5 : 8'($urandom);
            run_frame(vt[v].n, vt[v].set_last, vt[v].stall_at, 1'b0);
            verify($sformatf("vec%0d", v), vt[v].exp_hs, vt[v].exp_len, vt[v].exp_err, vt[v].exp_done);
            if (v == 0) begin
                mism = 0;
                for (int i = 0; i < 36 && i < rx_q.size(); i++)
                    if (rx_q[i] !== ((i < 31) ? 2'b01 : 2'b11)) mism++;
                check("preamble_sfd_first_hdr_byte", mism, 0);
            end
            repeat (2) @(negedge clk);
        end

        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 120);
            stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            for (int i = 0; i < 1600; i++) pl[i] = 8'($urandom);
            run_frame(n, 1'b1, stall, 1'b1);
            k    = (stall < 0) ? n : stall;
            elen = (stall < 0) ? 104 + 4 * ((n < 46) ? 46 : n) : 88 + 4 * k;
            verify($sformatf("rand%0d", f), k, elen, (stall < 0) ? 0 : 1, (stall < 0) ? 1 : 0);
            repeat (3) @(negedge clk);
        end

        // Asynchronous reset in the middle of PAYLOAD.
        for (int i = 0; i < 1600; i++) pl[i] = 8'(i);
        axiiv = 1'b1; axiid = pl[0]; axiilast = 1'b0; idx = 0;
        for (int c = 0; c < 600 && idx < 30; c++) begin
            @(negedge clk);
            if (axiiready) begin axiid = pl[idx]; idx++; end
        end
        repeat (6) @(negedge clk);
        check("midframe_txen_before", txen, 1);
        #3 rst = 1'b0;
        #1;
        check("midreset_txen", txen, 0);
        check("midreset_txd", txd, 0);
        check("midreset_busy", busy, 0);
        check("midreset_axiiready", axiiready, 0);
        check("midreset_tx_done", tx_done, 0);
        axiiv = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("postreset_txen", txen, 0);
        check("postreset_busy", busy, 0);
        check("postreset_tx_done", tx_done, 0);
        run_frame(60, 1'b1, -1, 1'b0);
        verify("after_reset", 60, 344, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ether_tx.md
Name: ether_tx

Overview:
- RMII transmit framer; the transmit-side counterpart of the ether/bitorder/cksum receive path, running on the 50 MHz RMII reference clock.
- Accepts payload bytes from an upstream byte FIFO and emits a complete Ethernet II frame as 2-bit dibits: preamble, SFD, header, payload, zero pad and CRC-32 FCS.
- Enforces the interpacket gap after every frame.

Parameters:
- DST_MAC, 48'hFF_FF_FF_FF_FF_FF, destination MAC address; most significant byte is sent first.
- SRC_MAC, 48'h69_69_5A_06_54_91, source MAC address; most significant byte is sent first.
- ETHERTYPE, 16'h88B5, EtherType field; most significant byte is sent first.
- MIN_PAYLOAD, 46, minimum payload length; shorter payloads are zero-padded to this length.
- MAX_PAYLOAD, 1500, maximum payload length in bytes.
- IFG_CYCLES, 48, number of idle cycles after a frame (12 bytes).

Ports:
- clk  in  1  50 MHz RMII clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- axiiv  in  1  payload byte valid.
- axiid  in  8  payload byte.
- axiilast  in  1  marks the final payload byte of the frame.
- axiiready  out  1  byte accepted this cycle when axiiv is also high.
- txen  out  1  RMII TX_EN.
- txd  out  2  RMII TXD; txd[0] carries the earlier bit.
- busy  out  1  high from frame start until the end of the IFG.
- tx_done  out  1  one-cycle pulse on the cycle after the last FCS dibit.
- tx_err  out  1  one-cycle pulse on an abort (underrun or oversize).

Behaviour:
- Reset:
  - rst low asynchronously forces state IDLE and clears all counters and the CRC.
  - While in reset: txen=0, txd=0, axiiready=0, busy=0, tx_done=0, tx_err=0.
  - Outputs are registered, except axiiready, which is combinational from state and counters.
- Bit order:
  - Each byte is sent as 4 dibits, LSB first: dibit k = {byte[2k+1], byte[2k]}.
  - One dibit per clock; a 2-bit dibit counter marks byte boundaries.
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG.
- IDLE:
  - axiiv=1 moves to PREAMBLE on the next edge.
  - No byte is consumed on entry.
  - txen rises on the first PREAMBLE cycle.
- PREAMBLE, 32 cycles:
  - 28 dibits of 2'b01 (0x55 bytes).
  - Then the SFD 0xD5 as dibits 01, 01, 01, 11.
- HEADER, 56 cycles:
  - 14 bytes, in order: DST_MAC, SRC_MAC, ETHERTYPE.
  - The CRC starts accumulating from the first header dibit.
- Byte fetch:
  - axiiready=1 only on dibit index 3 of the last header byte and of each non-final payload byte.
  - The byte is captured if axiiv=1 in that cycle.
- Underrun:
  - If axiiv=0 when axiiready=1, txen drops on the next cycle with no FCS.
  - tx_err pulses, and the block goes to IFG.
- PAYLOAD:
  - Sends the captured bytes and counts payload length.
  - After a byte captured with axiilast=1:
    - length < MIN_PAYLOAD: go to PAD.
    - otherwise: go to FCS.
- Oversize:
  - If byte MAX_PAYLOAD is captured without axiilast, it is treated as last.
  - tx_err pulses and the FCS is still sent.
  - Upstream must flush the remainder of the packet.
- PAD: sends 0x00 bytes until the payload length equals MIN_PAYLOAD; these bytes are included in the CRC.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Updated 2 bits per cycle over the header, payload and pad.
- FCS, 16 cycles:
  - Sends ~crc, LSB first.
  - The CRC register is frozen during FCS.
- IFG:
  - txen=0 and txd=0 for IFG_CYCLES cycles, then IDLE.
  - busy drops on IDLE entry.
  - axiiv is ignored during IFG.
- Frame length: txen-high time is exactly 32 + 56 + 4*max(N, MIN_PAYLOAD) + 16 cycles.
- Last-byte boundary: axiilast on a byte not presented with axiiv=1 has no effect.
- Reset mid-frame: txen=0 within the same cycle as rst assertion (asynchronous); no tx_done is generated.

Test Plan:
- 1-byte payload 0xA5, axiilast=1 -> txen high 288 cycles; 45 pad bytes of 0x00; exactly 1 axiiready handshake; tx_done at cycle 289; busy low 48 cycles later.
- 60-byte payload 0x00..0x3B -> no PAD state; txen high 344 cycles; loopback through the ether, bitorder and cksum modules shows cksum done=1 and kill=0; bytes after bitorder match the header, then 0x00..0x3B.
- First dibits after reset -> txd = 01 ×28, then 01, 01, 01, 11; first header byte 0xFF sent as 11 ×4.
- Underrun: axiiv held low on the 10th payload fetch -> txen falls the next cycle; tx_err pulses once; no tx_done; busy stays high for 48 cycles.
- Oversize: 1501 bytes with axiilast never set -> exactly 1500 handshakes, tx_err pulse, valid FCS (cksum kill=0).
- rst pulsed low in the middle of PAYLOAD -> txen=0 immediately; after release all outputs are 0, state is IDLE, and the next frame is transmitted correctly.
